// File: rtl/tros_pkg.sv
// rtl/tros_pkg.sv - shared types and sizing helpers for the ring-oscillator readout serialiser
package tros_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        NEXT
    } tros_state_e;

    localparam logic [3:0] TROS_PREAMBLE = 4'b1010;

    function automatic int idx_w(input int num_ch);
        return (num_ch <= 2) ? 1 : $clog2(num_ch);
    endfunction

    function automatic int frame_w(input int pre_w, input int num_ch, input int cnt_w);
        return pre_w + idx_w(num_ch) + cnt_w + 1;
    endfunction

endpackage

// File: rtl/tros_sync2.sv
// rtl/tros_sync2.sv - two-flop pin synchroniser with hold enable
module tros_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else if (en) begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tros_multi_readout.sv
// rtl/tros_multi_readout.sv - N-channel framed, parity-protected serial readout of cycle counts
module tros_multi_readout
    import tros_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 20,
    parameter int PRE_W  = 4,
    parameter logic [PRE_W-1:0] PREAMBLE = PRE_W'(TROS_PREAMBLE),
    localparam int IDX_W = idx_w(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic                    latch_req,
    input  logic [IDX_W-1:0]        chan_sel,
    input  logic                    all_mode,
    input  logic [NUM_CH*CNT_W-1:0] cycle_count,
    output logic                    serial_bit,
    output logic                    manchester_out,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    overrun
);

    localparam int FRAME_W = frame_w(PRE_W, NUM_CH, CNT_W);
    localparam int BIT_W   = $clog2(FRAME_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);
    localparam logic [IDX_W-1:0] LAST_CH  = IDX_W'(NUM_CH - 1);

    tros_state_e        state, state_nxt;
    logic               req_sync, req_prev, req_rise;
    logic [BIT_W-1:0]   bit_cnt;
    logic [IDX_W-1:0]   ch;
    logic               all_q;
    logic [CNT_W-1:0]   snap [NUM_CH];
    logic [FRAME_W-1:0] shreg;
    logic [IDX_W-1:0]   start_idx, next_idx;
    logic [CNT_W-1:0]   start_cnt, next_cnt;
    logic               last_bit, last_frame;
    logic               do_start, do_next, do_shift, do_end;

    function automatic logic [FRAME_W-1:0] build_frame(input logic [IDX_W-1:0] idx,
                                                        input logic [CNT_W-1:0] cnt);
        return {PREAMBLE, idx, cnt, ^{idx, cnt}};
    endfunction

    tros_sync2 u_req_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ena),
        .d     (latch_req),
        .q     (req_sync)
    );

    assign req_rise   = req_sync & ~req_prev;
    assign last_bit   = (bit_cnt == LAST_BIT);
    assign last_frame = !all_q || (ch == LAST_CH);
    assign start_idx  = all_mode ? '0 : chan_sel;
    assign next_idx   = ch + 1'b1;

    // Out-of-range selections fall through the loops and read as zero.
    always_comb begin
        start_cnt = '0;
        next_cnt  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (start_idx == IDX_W'(k))
                start_cnt = cycle_count[k*CNT_W +: CNT_W];
            if (next_idx == IDX_W'(k))
                next_cnt = snap[k];
        end
    end

    always_comb begin
        state_nxt = state;
        do_start  = 1'b0;
        do_next   = 1'b0;
        do_shift  = 1'b0;
        do_end    = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_rise) begin
                    do_start  = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD, SHIFT, NEXT: begin
                if (!last_bit) begin
                    do_shift  = 1'b1;
                    state_nxt = SHIFT;
                end else if (last_frame) begin
                    do_end    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    do_next   = 1'b1;
                    state_nxt = NEXT;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else if (ena)
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_prev <= 1'b0;
            overrun  <= 1'b0;
            all_q    <= 1'b0;
            ch       <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            for (int k = 0; k < NUM_CH; k++)
                snap[k] <= '0;
        end else if (ena) begin
            req_prev <= req_sync;
            // An accepted edge clears overrun; an edge while busy sets it.
            if (req_rise)
                overrun <= busy;
            if (do_start) begin
                all_q   <= all_mode;
                ch      <= start_idx;
                bit_cnt <= '0;
                shreg   <= build_frame(start_idx, start_cnt);
                for (int k = 0; k < NUM_CH; k++)
                    if (all_mode || chan_sel == IDX_W'(k))
                        snap[k] <= cycle_count[k*CNT_W +: CNT_W];
            end else if (do_next) begin
                ch      <= next_idx;
                bit_cnt <= '0;
                shreg   <= build_frame(next_idx, next_cnt);
            end else if (do_shift) begin
                bit_cnt <= bit_cnt + 1'b1;
                shreg   <= {shreg[FRAME_W-2:0], 1'b0};
            end else if (do_end) begin
                bit_cnt <= '0;
                shreg   <= '0;
            end
        end
    end

    assign serial_bit     = shreg[FRAME_W-1];
    assign manchester_out = serial_bit ^ clk;
    assign busy           = (state != IDLE);
    assign frame_done     = busy & last_bit & last_frame;

endmodule

// File: tb/tb_tros_multi_readout.sv
// tb/tb_tros_multi_readout.sv - self-checking bench for tros_multi_readout
module tb_tros_multi_readout;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        all_mode;
    logic        latch_req, latch_req3;
    logic [1:0]  chan_sel, chan_sel3;
    logic [79:0] cycle_count;
    logic [59:0] cycle_count3;
    logic        serial_bit, manchester_out, busy, frame_done, overrun;
    logic        serial_bit3, manchester_out3, busy3, frame_done3, overrun3;

    int checks = 0;
    int errors = 0;
    logic [127:0] exp_v;
    int exp_n;

    typedef struct {
        bit          all_m;
        logic [1:0]  sel;
        logic [19:0] cnt;
        logic [26:0] exp;
    } vec_t;
    vec_t tbl[5];

    tros_multi_readout u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ena            (ena),
        .latch_req      (latch_req),
        .chan_sel       (chan_sel),
        .all_mode       (all_mode),
        .cycle_count    (cycle_count),
        .serial_bit     (serial_bit),
        .manchester_out (manchester_out),
        .busy           (busy),
        .frame_done     (frame_done),
        .overrun        (overrun)
    );

    tros_multi_readout #(.NUM_CH(3)) u_dut3 (
        .clk            (clk),
        .rst_n          (rst_n),
        .ena            (ena),
        .latch_req      (latch_req3),
        .chan_sel       (chan_sel3),
        .all_mode       (all_mode),
        .cycle_count    (cycle_count3),
        .serial_bit     (serial_bit3),
        .manchester_out (manchester_out3),
        .busy           (busy3),
        .frame_done     (frame_done3),
        .overrun        (overrun3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic o_sb(input bit u);
        return u ? serial_bit3 : serial_bit;
    endfunction
    function automatic logic o_man(input bit u);
        return u ? manchester_out3 : manchester_out;
    endfunction
    function automatic logic o_busy(input bit u);
        return u ? busy3 : busy;
    endfunction
    function automatic logic o_fd(input bit u);
        return u ? frame_done3 : frame_done;
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push_bit(input logic b);
        exp_v = {exp_v[126:0], b};
        exp_n++;
    endtask

    // Reference frame: preamble, 2-bit index, 20-bit count, XOR of index+count bits.
    task automatic push_frame(input int idx, input int cnt);
        logic [3:0] pre_bits;
        int ones;
        logic b;
        pre_bits = 4'b1010;
        ones = 0;
        for (int i = 3; i >= 0; i--) push_bit(pre_bits[i]);
        for (int i = 1; i >= 0; i--) begin
            b = 1'((idx >> i) & 1);
            ones += int'(b);
            push_bit(b);
        end
        for (int i = 19; i >= 0; i--) begin
            b = 1'((cnt >> i) & 1);
            ones += int'(b);
            push_bit(b);
        end
        push_bit(1'(ones % 2));
    endtask

    task automatic clear_exp();
        exp_v = '0;
        exp_n = 0;
    endtask

    task automatic set_req(input bit u, input logic v);
        if (u) latch_req3 = v;
        else   latch_req  = v;
    endtask

    task automatic xfer(input string name, input bit use3, input int freeze_at,
                        input int ovr_at, input bit scramble);
        logic [127:0] got;
        int fd_n, busy_n, wait_n, side_n;
        bit fd_ok, man_ok, frz_ok;
        logic held;
        got = '0; fd_n = 0; busy_n = 0; wait_n = 0; side_n = 0;
        fd_ok = 1; man_ok = 1; frz_ok = 1;
        @(negedge clk);
        set_req(use3, 1'b1);
        @(negedge clk);
        set_req(use3, 1'b0);
        fork
            begin
                while (!o_busy(use3) && wait_n < 10) begin
                    @(negedge clk);
                    wait_n++;
                end
                check({name, "_latency"}, wait_n, 2);
                for (int i = 0; i < exp_n; i++) begin
                    got = {got[126:0], o_sb(use3)};
                    if (o_fd(use3)) begin
                        fd_n++;
                        if (i != exp_n - 1) fd_ok = 0;
                    end
                    if (o_busy(use3)) busy_n++;
                    if (o_man(use3) !== o_sb(use3)) man_ok = 0;
                    if (i == freeze_at) begin
                        held = o_sb(use3);
                        ena = 1'b0;
                        repeat (5) begin
                            @(posedge clk); #1;
                            if (o_sb(use3) !== held || o_man(use3) !== ~held) frz_ok = 0;
                            @(negedge clk);
                        end
                        ena = 1'b1;
                    end
                    @(posedge clk); #1;
                    if (o_man(use3) !== ~o_sb(use3)) man_ok = 0;
                    @(negedge clk);
                end
            end
            begin
                if (ovr_at >= 0 || scramble) begin
                    while (!o_busy(use3) && side_n < 10) begin
                        @(negedge clk);
                        side_n++;
                    end
                    if (scramble) begin
                        @(negedge clk);
                        cycle_count  = {$urandom, $urandom, 16'($urandom)};
                        cycle_count3 = {$urandom, 28'($urandom)};
                    end
                    if (ovr_at >= 0) begin
                        repeat (ovr_at - (scramble ? 1 : 0)) @(negedge clk);
                        set_req(use3, 1'b1);
                        @(negedge clk);
                        set_req(use3, 1'b0);
                    end
                end
            end
        join
        check({name, "_bits"}, got, exp_v);
        check({name, "_frame_done"}, {fd_ok, 31'(fd_n)}, {1'b1, 31'd1});
        check({name, "_busy_cycles"}, busy_n, exp_n);
        check({name, "_end_idle"}, {o_busy(use3), o_sb(use3)}, 2'b00);
        check({name, "_manchester"}, man_ok, 1'b1);
        if (freeze_at >= 0) check({name, "_ena_hold"}, frz_ok, 1'b1);
    endtask

    initial begin
        tbl[0] = '{1'b0, 2'd2, 20'hABCDE, {4'b1010, 2'b10, 20'hABCDE, 1'b0}};
        tbl[1] = '{1'b0, 2'd0, 20'h00000, {4'b1010, 2'b00, 20'h00000, 1'b0}};
        tbl[2] = '{1'b0, 2'd3, 20'hFFFFF, {4'b1010, 2'b11, 20'hFFFFF, 1'b0}};
        tbl[3] = '{1'b0, 2'd1, 20'h00003, {4'b1010, 2'b01, 20'h00003, 1'b1}};
        tbl[4] = '{1'b0, 2'd0, 20'h80000, {4'b1010, 2'b00, 20'h80000, 1'b1}};

        rst_n = 1'b0; ena = 1'b1; all_mode = 1'b0;
        latch_req = 1'b0; latch_req3 = 1'b0;
        chan_sel = '0; chan_sel3 = '0;
        cycle_count = '0; cycle_count3 = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {serial_bit, busy, frame_done, overrun}, 4'b0000);
        check("reset_outputs3", {serial_bit3, busy3, frame_done3, overrun3}, 4'b0000);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        foreach (tbl[t]) begin
            all_mode = tbl[t].all_m;
            chan_sel = tbl[t].sel;
            cycle_count = {$urandom, $urandom, 16'($urandom)};
            cycle_count[tbl[t].sel*20 +: 20] = tbl[t].cnt;
            clear_exp();
            exp_v = {101'd0, tbl[t].exp};
            exp_n = 27;
            xfer($sformatf("table%0d", t), 1'b0, -1, -1, 1'b0);
            check($sformatf("table%0d_overrun", t), overrun, 1'b0);
        end

        all_mode = 1'b1;
        chan_sel = 2'd3;
        cycle_count = {20'd4, 20'd3, 20'd2, 20'd1};
        clear_exp();
        for (int k = 0; k < 4; k++) push_frame(k, k + 1);
        xfer("all_mode_freeze", 1'b0, 40, -1, 1'b1);

        all_mode = 1'b0;
        chan_sel = 2'd1;
        cycle_count = {$urandom, $urandom, 16'($urandom)};
        clear_exp();
        push_frame(1, int'(cycle_count[20 +: 20]));
        xfer("overrun", 1'b0, -1, 10, 1'b0);
        check("overrun_set", overrun, 1'b1);

        chan_sel = 2'd3;
        clear_exp();
        push_frame(3, int'(cycle_count[60 +: 20]));
        xfer("overrun_clear", 1'b0, -1, -1, 1'b0);
        check("overrun_cleared", overrun, 1'b0);

        chan_sel = 2'd0;
        clear_exp();
        push_frame(0, int'(cycle_count[0 +: 20]));
        xfer("last_bit_edge", 1'b0, -1, 24, 1'b0);
        check("last_bit_edge_overrun", overrun, 1'b1);
        repeat (4) @(negedge clk);
        check("last_bit_edge_no_restart", busy, 1'b0);

        ena = 1'b0;
        @(negedge clk); latch_req = 1'b1;
        @(negedge clk); latch_req = 1'b0;
        @(negedge clk); ena = 1'b1;
        repeat (8) @(negedge clk);
        check("ena_low_edge_dropped", busy, 1'b0);

        chan_sel = 2'd2;
        @(negedge clk); latch_req = 1'b1;
        @(negedge clk); latch_req = 1'b0;
        repeat (2) @(negedge clk);
        repeat (12) @(negedge clk);
        check("reset_mid_busy_before", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("reset_mid_async", {serial_bit, busy, frame_done, overrun}, 4'b0000);
        @(negedge clk); rst_n = 1'b1;
        clear_exp();
        push_frame(2, int'(cycle_count[40 +: 20]));
        xfer("after_reset", 1'b0, -1, -1, 1'b0);

        for (int r = 0; r < 8; r++) begin
            all_mode = 1'($urandom_range(0, 1));
            chan_sel = 2'($urandom_range(0, 3));
            cycle_count = {$urandom, $urandom, 16'($urandom)};
            clear_exp();
            if (all_mode)
                for (int k = 0; k < 4; k++) push_frame(k, int'(cycle_count[k*20 +: 20]));
            else
                push_frame(int'(chan_sel), int'(cycle_count[chan_sel*20 +: 20]));
            xfer($sformatf("rand%0d", r), 1'b0, -1, -1, 1'b1);
        end

        all_mode = 1'b0;
        chan_sel3 = 2'd3;
        cycle_count3 = {$urandom, 28'($urandom)};
        clear_exp();
        push_frame(3, 0);
        xfer("out_of_range", 1'b1, -1, -1, 1'b0);

        all_mode = 1'b1;
        cycle_count3 = {$urandom, 28'($urandom)};
        clear_exp();
        for (int k = 0; k < 3; k++) push_frame(k, int'(cycle_count3[k*20 +: 20]));
        xfer("all_mode3", 1'b1, -1, -1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
